// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter driving a 4:1 mux select, with a bounded hold
// time, forced release at MAX_HOLD and a guaranteed idle bubble between grants.
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       nxt;
    logic             at_max;
    logic             owner_req;

    // Lowest offset from last wins; offset 4 (the last-served channel) is checked last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = l;
        for (int unsigned k = 4; k >= 1; k--) begin
            cand = l + 2'(k);
            if (r[cand]) idx = cand;
        end
        return idx;
    endfunction

    always_comb begin
        nxt       = pick(req, last);
        at_max    = (cnt == CNT_W'(MAX_HOLD - 1));
        owner_req = req[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            last    <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        grant <= 4'b0001 << nxt;
                        sel   <= nxt;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    cnt <= cnt + 1'b1;
                    if (done || !owner_req || at_max) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        last    <= sel;
                        // Timeout flags only a release forced purely by the hold limit.
                        timeout <= at_max && !done && owner_req;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
